// File: rtl/hadamard_product_unit_if.sv
// Hadamard product unit handshake and data bundle.
// Carries the pass request, the transformed operands and the result matrix.
interface hadamard_product_unit_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int TILE   = 6
);
  logic start;
  logic accumulate;
  logic [0:TILE-1][0:TILE-1][DATA_W-1:0] kernel_in;
  logic [0:TILE-1][0:TILE-1][DATA_W-1:0] tile_in;
  logic [0:TILE-1][0:TILE-1][OUT_W-1:0]  result_out;
  logic busy;
  logic done;

  modport master (
    output start,
    output accumulate,
    output kernel_in,
    output tile_in,
    input  result_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  accumulate,
    input  kernel_in,
    input  tile_in,
    output result_out,
    output busy,
    output done
  );
endinterface

// File: rtl/hadamard_product_unit.sv
// Winograd-domain element-wise product, one row per cycle.
// Optionally accumulates onto the previous result for channel sums.
module hadamard_product_unit #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int TILE   = 6
) (
  input  logic clk,
  input  logic rst_n,
  hadamard_product_unit_if.slave bus
);
  localparam int RW = (TILE > 1) ? $clog2(TILE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [0:TILE-1][0:TILE-1][DATA_W-1:0] op_t;
  typedef logic [0:TILE-1][0:TILE-1][OUT_W-1:0]  res_t;

  state_t        state;
  logic [RW-1:0] row;
  op_t           k_q;
  op_t           t_q;
  logic          acc_q;
  res_t          res;
  logic          busy_q;
  logic          done_q;
  logic          accept;
  logic [OUT_W-1:0] prod [TILE];

  // The DONE cycle doubles as the first free slot for back-to-back passes.
  always_comb begin
    accept = bus.start && (state == IDLE || state == DONE);
  end

  // One signed multiplier per column, fed from the current row.
  always_comb begin
    for (int c = 0; c < TILE; c++) begin
      prod[c] = OUT_W'($signed(k_q[row][c]))
              * OUT_W'($signed(t_q[row][c]));
    end
  end

  // Pass sequencer, operand capture and row-wise result update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      row    <= '0;
      k_q    <= '0;
      t_q    <= '0;
      acc_q  <= 1'b0;
      res    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        k_q   <= bus.kernel_in;
        t_q   <= bus.tile_in;
        acc_q <= bus.accumulate;
      end
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            row    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int c = 0; c < TILE; c++) begin
            res[row][c] <= (acc_q ? res[row][c] : '0) + prod[c];
          end
          if (row == RW'(TILE - 1)) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            row <= row + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            row   <= '0;
            state <= RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.result_out = res;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_hadamard_product_unit.sv
// Bench for hadamard_product_unit: pass-level reference model plus
// directed literal checks and randomized traffic.
module tb_hadamard_product_unit;
  localparam int DW = 16;
  localparam int OW = 32;
  localparam int T  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hadamard_product_unit_if #(.DATA_W(DW), .OUT_W(OW), .TILE(T)) bus ();

  hadamard_product_unit #(.DATA_W(DW), .OUT_W(OW), .TILE(T)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a pass is a timeline of T+1 cycles since acceptance.
  // base = committed results, tgt = results at the end of the pass.
  logic [OW-1:0] base [T][T];
  logic [OW-1:0] tgt  [T][T];
  bit active = 1'b0;
  int age = 0;

  function automatic logic [OW-1:0] expv(int r, int c);
    return (active && age >= r + 1) ? tgt[r][c] : base[r][c];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 1'b0;
      age = 0;
      for (int r = 0; r < T; r++)
        for (int c = 0; c < T; c++) begin
          base[r][c] = '0;
          tgt[r][c] = '0;
        end
    end else begin
      if (active) begin
        age++;
        if (age == T) base = tgt;
        if (age == T + 1) active = 1'b0;
      end
      if (!active && bus.start) begin
        for (int r = 0; r < T; r++)
          for (int c = 0; c < T; c++) begin
            longint p;
            p = longint'($signed(bus.kernel_in[r][c]))
              * longint'($signed(bus.tile_in[r][c]));
            tgt[r][c] = (bus.accumulate ? base[r][c] : '0) + OW'(p);
          end
        active = 1'b1;
        age = 0;
      end
    end
  end

  task automatic chk(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference.
  always @(negedge clk) begin
    int br;
    int bc;
    bit seen;
    br = 0;
    bc = 0;
    seen = 1'b0;
    chk("busy", OW'(bus.busy), OW'(active));
    chk("done", OW'(bus.done), OW'(active && age == T));
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++)
        if (!seen && bus.result_out[r][c] !== expv(r, c)) begin
          seen = 1'b1;
          br = r;
          bc = c;
        end
    chk($sformatf("result[%0d][%0d]", br, bc),
        bus.result_out[br][bc], expv(br, bc));
  end

  task automatic fill(input logic [DW-1:0] k, input logic [DW-1:0] t);
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) begin
        bus.kernel_in[r][c] = k;
        bus.tile_in[r][c] = t;
      end
  endtask

  function automatic logic [DW-1:0] rnd();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7fff;
      2: return 16'hffff;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic fill_rnd();
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) begin
        bus.kernel_in[r][c] = rnd();
        bus.tile_in[r][c] = rnd();
      end
  endtask

  // Run one pass; report edge of first done and busy cycles seen.
  task automatic pass(input bit acc, output int lat, output int bcyc,
                      output int ndone);
    @(negedge clk);
    bus.accumulate = acc;
    bus.start = 1'b1;
    lat = -1;
    bcyc = 0;
    ndone = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.start = 1'b0;
      if (bus.busy) bcyc++;
      if (bus.done) ndone++;
      if (bus.done && lat < 0) lat = i;
    end
  endtask

  initial begin
    int lat;
    int bcyc;
    int nd;
    bus.start = 1'b0;
    bus.accumulate = 1'b0;
    fill('0, '0);
    repeat (3) @(negedge clk);
    chk("reset_res", bus.result_out[2][4], '0);
    chk("reset_busy", OW'(bus.busy), '0);
    rst_n = 1'b1;

    // First pass after reset with accumulate adds to zero.
    fill(16'd3, 16'hfffb);
    pass(1'b1, lat, bcyc, nd);
    chk("acc_from_zero", bus.result_out[1][2], 32'hfffffff1);

    // Unit operands: latency, busy length, plain product.
    fill(16'd1, 16'd2);
    pass(1'b0, lat, bcyc, nd);
    chk("lat_edges", OW'(lat), 32'd7);
    chk("busy_cycles", OW'(bcyc), 32'd7);
    chk("ones_twos_00", bus.result_out[0][0], 32'd2);
    chk("ones_twos_55", bus.result_out[5][5], 32'd2);

    // Index kernel times -1, then accumulate the same again.
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) begin
        bus.kernel_in[r][c] = DW'(r * 6 + c);
        bus.tile_in[r][c] = 16'hffff;
      end
    pass(1'b0, lat, bcyc, nd);
    chk("passA_55", bus.result_out[5][5], 32'hffffffdd);
    pass(1'b1, lat, bcyc, nd);
    chk("passB_55", bus.result_out[5][5], -32'sd70);
    chk("passB_01", bus.result_out[0][1], -32'sd2);

    // Most negative operands, then wrap on accumulation.
    fill(16'h8000, 16'h8000);
    pass(1'b0, lat, bcyc, nd);
    chk("minmin", bus.result_out[3][3], 32'h40000000);
    pass(1'b1, lat, bcyc, nd);
    chk("minmin_wrap", bus.result_out[3][3], 32'h80000000);

    // Re-pulsed start mid-pass with changed inputs is ignored.
    fill(16'd3, 16'd5);
    @(negedge clk);
    bus.accumulate = 1'b0;
    bus.start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      bus.start = (i == 2 || i == 5);
      if (bus.start) begin
        bus.accumulate = 1'b1;
        fill(16'd7, 16'd7);
      end
      if (bus.done) nd++;
    end
    chk("repulse_done_cnt", OW'(nd), 32'd1);
    chk("repulse_44", bus.result_out[4][4], 32'd15);

    // Reset dropped mid-pass aborts with no done pulse.
    fill(16'd9, 16'd9);
    @(negedge clk);
    bus.accumulate = 1'b0;
    bus.start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", OW'(bus.busy), '0);
    chk("abort_done", OW'(bus.done), '0);
    chk("abort_res", bus.result_out[0][0], '0);
    nd = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    chk("abort_no_done", OW'(nd), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", OW'(bus.busy), '0);
    fill(16'hfffe, 16'd4);
    pass(1'b0, lat, bcyc, nd);
    chk("after_abort", bus.result_out[2][2], 32'hfffffff8);
    chk("after_abort_lat", OW'(lat), 32'd7);

    // Start held high: passes accepted every 7 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    nd = 0;
    for (int i = 0; i < 21; i++) begin
      bus.accumulate = 1'($urandom);
      fill_rnd();
      @(posedge clk);
      #1;
      if (bus.done) nd++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("b2b_dones", OW'(nd), 32'd3);

    // Random traffic; inputs change every cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      fill_rnd();
      bus.start = ($urandom_range(0, 3) == 0);
      bus.accumulate = 1'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
